// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Purpose  : Shared geometry constants and types for the 32x64 masked 1R1W
//            SRAM controller.
// Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam int DEPTH     = 32;
    localparam int WIDTH     = 64;
    localparam int MASK_GRAN = 8;
    localparam int LANES     = WIDTH / MASK_GRAN;
    localparam int ADDR_W    = $clog2(DEPTH);

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
        logic [LANES-1:0]  mask;
    } wr_req_t;

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_rr_arb2
// Purpose  : Two-way round-robin arbiter. A lone requester always wins; when
//            both request, the one not granted last time wins. The priority
//            pointer only moves on a grant and starts favouring requester 0.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant,
    output logic       o_grant_idx
);

    logic r_prio;

    // Pick the winner from the request pattern and the priority pointer
    always_comb begin
        o_grant     = 2'b00;
        o_grant_idx = 1'b0;
        case (i_valid)
            2'b01: begin
                o_grant     = 2'b01;
                o_grant_idx = 1'b0;
            end
            2'b10: begin
                o_grant     = 2'b10;
                o_grant_idx = 1'b1;
            end
            2'b11: begin
                o_grant     = r_prio ? 2'b10 : 2'b01;
                o_grant_idx = r_prio;
            end
            default: begin
                o_grant     = 2'b00;
                o_grant_idx = 1'b0;
            end
        endcase
    end

    // After a grant, favour the other requester next time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (|i_valid) begin
            r_prio <= ~o_grant_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_1r1w_masked_32x64_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_1r1w_masked_32x64_ctrl
// Purpose  : Owns the 32x64 byte-masked 1R1W SRAM wrapper. Clears all words
//            after reset, round-robin shares the write port between two
//            masked writers and sequences reads with a registered response.
// Config   : MEM_CTRL_BYPASS_EN - when defined, a read colliding with a
//            same-cycle write is accepted and the written lanes are merged
//            into the response; otherwise the read is stalled one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mem_1r1w_masked_32x64_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    output logic              init_done,
    input  logic              w0_valid,
    output logic              w0_ready,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [WIDTH-1:0]  w0_data,
    input  logic [LANES-1:0]  w0_mask,
    input  logic              w1_valid,
    output logic              w1_ready,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [WIDTH-1:0]  w1_data,
    input  logic [LANES-1:0]  w1_mask,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic [ADDR_W-1:0] R0_addr,
    output logic              R0_en,
    input  logic [WIDTH-1:0]  R0_data,
    output logic [ADDR_W-1:0] W0_addr,
    output logic              W0_en,
    output logic [WIDTH-1:0]  W0_data,
    output logic [LANES-1:0]  W0_mask
);

    ctrl_state_e       r_state;
    logic [ADDR_W-1:0] r_init_cnt;
    logic              r_init_we;
    logic              r_rsp_valid;

    logic              w_run;
    logic [1:0]        w_wr_valid;
    logic [1:0]        w_wr_grant;
    logic              w_wr_idx;
    logic              w_wr_en;
    wr_req_t           w_wr_req;
    logic              w_collision;
    logic              w_collision_stall;
    logic [WIDTH-1:0]  w_rsp_merged;

    assign w_run      = (r_state == RUN);
    assign init_done  = w_run;
    assign w_wr_valid = {w1_valid, w0_valid} & {2{w_run}};

    mem_ctrl_rr_arb2 u_arb (
        .clk         (clock),
        .rst_n       (reset_n),
        .i_valid     (w_wr_valid),
        .o_grant     (w_wr_grant),
        .o_grant_idx (w_wr_idx)
    );

    assign w_wr_en  = |w_wr_grant;
    assign w0_ready = w_wr_grant[0];
    assign w1_ready = w_wr_grant[1];

    // Select the granted requester's write fields
    always_comb begin
        if (w_wr_idx) begin
            w_wr_req.addr = w1_addr;
            w_wr_req.data = w1_data;
            w_wr_req.mask = w1_mask;
        end else begin
            w_wr_req.addr = w0_addr;
            w_wr_req.data = w0_data;
            w_wr_req.mask = w0_mask;
        end
    end

    // Clear sweep while initialising, otherwise the granted write; idle is all-zero
    always_comb begin
        W0_en   = 1'b0;
        W0_addr = '0;
        W0_data = '0;
        W0_mask = '0;
        if (r_init_we) begin
            W0_en   = 1'b1;
            W0_addr = r_init_cnt;
            W0_mask = '1;
        end else if (w_wr_en) begin
            W0_en   = 1'b1;
            W0_addr = w_wr_req.addr;
            W0_data = w_wr_req.data;
            W0_mask = w_wr_req.mask;
        end
    end

    assign w_collision = rd_valid && w_wr_en && (rd_addr == w_wr_req.addr);

`ifdef MEM_CTRL_BYPASS_EN
    assign w_collision_stall = 1'b0;
`else
    assign w_collision_stall = w_collision;
`endif

    assign rd_ready = w_run && (!r_rsp_valid || rsp_ready) && !w_collision_stall;
    assign R0_en    = rd_valid && rd_ready;
    assign R0_addr  = R0_en ? rd_addr : '0;

    // Init/run sequencing: the write enable is registered so every output is
    // zero while reset is held, and the sweep covers addresses 0..DEPTH-1
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
            r_init_we  <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    if (!r_init_we) begin
                        r_init_we <= 1'b1;
                    end else if (r_init_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_init_we  <= 1'b0;
                        r_init_cnt <= '0;
                        r_state    <= RUN;
                    end else begin
                        r_init_cnt <= r_init_cnt + ADDR_W'(1);
                    end
                end
                RUN: begin
                    r_init_we <= 1'b0;
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

    // Response valid: set by an accepted read, cleared when consumed
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
        end else if (R0_en) begin
            r_rsp_valid <= 1'b1;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef MEM_CTRL_BYPASS_EN
    logic             r_byp_hit;
    logic [WIDTH-1:0] r_byp_data;
    logic [LANES-1:0] r_byp_mask;

    // Capture the colliding write alongside the read so it can be merged
    // over the macro's pre-write output; held until the next accepted read
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_byp_hit  <= 1'b0;
            r_byp_data <= '0;
            r_byp_mask <= '0;
        end else if (R0_en) begin
            r_byp_hit  <= w_collision;
            r_byp_data <= w_wr_req.data;
            r_byp_mask <= w_wr_req.mask;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_rsp_merged[i*MASK_GRAN +: MASK_GRAN] =
            (r_byp_hit && r_byp_mask[i]) ? r_byp_data[i*MASK_GRAN +: MASK_GRAN]
                                         : R0_data[i*MASK_GRAN +: MASK_GRAN];
    end
`else
    assign w_rsp_merged = R0_data;
`endif

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_valid ? w_rsp_merged : '0;

endmodule
`default_nettype wire
